// File: rtl/ps2_event_rx_pkg.sv
// Shared definitions for the PS/2 event receiver: deframer state encodings,
// prefix byte values and the layout of one buffered key event.
package ps2_event_rx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam int EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO for the PS/2 receiver: simultaneous push/pop always allowed,
// pushes into a full FIFO without a pop are dropped and flagged.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow <= push && full && !do_pop;
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: pin filtering, 11-bit deframing with parity/stop checks,
// per-frame watchdog, E0/F0 prefix folding and a valid/ready event FIFO.
module ps2_event_rx
    import ps2_event_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8,
    parameter int LVL_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2c,
    input  logic             ps2d,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic [LVL_W-1:0] fifo_level,
    output logic             parity_err,
    output logic             frame_err,
    output logic             timeout,
    output logic             overflow
);

    localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

    logic            ps2c_s1;
    logic            ps2c_s2;
    logic            ps2d_s1;
    logic            ps2d_s2;
    logic            filt_c;
    logic            filt_c_d;
    logic [FCW-1:0]  filt_cnt;
    logic            fall;

    logic [1:0]      state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [WDW-1:0]  wd_cnt;
    logic            wd_fire;

    logic            acc_valid;
    logic [7:0]      acc_byte;
    logic            ext_flag;
    logic            brk_flag;
    logic            push;
    ps2_evt_t        push_evt;
    ps2_evt_t        head_evt;
    logic            fifo_full;
    logic            fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_s1 <= 1'b1;
            ps2c_s2 <= 1'b1;
            ps2d_s1 <= 1'b1;
            ps2d_s2 <= 1'b1;
        end else begin
            ps2c_s1 <= ps2c;
            ps2c_s2 <= ps2c_s1;
            ps2d_s1 <= ps2d;
            ps2d_s2 <= ps2d_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN back-to-back samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_c   <= 1'b1;
            filt_c_d <= 1'b1;
            filt_cnt <= '0;
        end else begin
            filt_c_d <= filt_c;
            if (ps2c_s2 == filt_c) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_c   <= ps2c_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_c_d && !filt_c;

    // A fall in the same cycle counts as progress, so it suppresses the watchdog.
    assign wd_fire = (state != ST_IDLE) && !fall && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            acc_valid  <= 1'b0;
            acc_byte   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            acc_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;

            if (state == ST_IDLE || fall) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (wd_fire) begin
                state   <= ST_IDLE;
                bitcnt  <= '0;
                shreg   <= '0;
                par_bit <= 1'b0;
                timeout <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!ps2d_s2) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg  <= {ps2d_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            state <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        par_bit <= ps2d_s2;
                        state   <= ST_STOP;
                    end
                    default: begin
                        // Parity is reported in preference to a bad stop bit.
                        state <= ST_IDLE;
                        if (!odd_parity_ok(shreg, par_bit)) begin
                            parity_err <= 1'b1;
                        end else if (!ps2d_s2) begin
                            frame_err <= 1'b1;
                        end else begin
                            acc_valid <= 1'b1;
                            acc_byte  <= shreg;
                        end
                    end
                endcase
            end
        end
    end

    assign push          = acc_valid && (acc_byte != PS2_PFX_EXT) && (acc_byte != PS2_PFX_BRK);
    assign push_evt.ext  = ext_flag;
    assign push_evt.brk  = brk_flag;
    assign push_evt.code = acc_byte;

    // Prefix flags accumulate until a real scancode consumes them or the frame stream breaks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (parity_err || frame_err || timeout || push) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (acc_valid) begin
            if (acc_byte == PS2_PFX_EXT) begin
                ext_flag <= 1'b1;
            end
            if (acc_byte == PS2_PFX_BRK) begin
                brk_flag <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W),
        .LW    (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (push_evt),
        .pop      (evt_ready),
        .dout     (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_brk   = head_evt.brk;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
